// File: rtl/mlaccel_memory_arbiter.sv
// mlaccel_memory_arbiter
//   Shares one single-port accelerator memory among NUM_REQ requesters.
//   Round-robin grant with a valid/ready handshake per requester, a registered
//   issue stage driving the memory port, and a tag pipeline that routes read
//   data back to the issuing requester in issue order.
//
//   Handshake: a requester raises req_valid and holds addr/wen/wdata stable
//   until req_ready; a transfer happens in any cycle where valid and ready are
//   both high. Responses are not back-pressurable: rsp_valid is a one-cycle
//   pulse exactly RD_LATENCY+1 cycles after the read was accepted.
//
//   Optional build macro: MLACCEL_MEMARB_PRIO_EN
//     defined   -> requester 0 has strict priority; the others round-robin
//                  among themselves (rr_ptr never points at 0 after a grant).
//     undefined -> every requester sits in one round-robin ring.
module mlaccel_memory_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [17*NUM_REQ-1:0] req_addr,
  input  logic [4*NUM_REQ-1:0]  req_wen,
  input  logic [32*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [16:0]           mem_addr,
  output logic [3:0]            mem_wen,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STAGES = RD_LATENCY + 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

`ifdef MLACCEL_MEMARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  // Arbitration state and combinational grant results
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    w_rr_next;
  logic               w_found;
  logic               w_accept;
  logic [ID_W-1:0]    w_win_id;
  logic [NUM_REQ-1:0] w_grant;

  // Winner's request fields
  logic [16:0]        w_sel_addr;
  logic [3:0]         w_sel_wen;
  logic [31:0]        w_sel_wdata;

  // Issue stage registers
  logic [16:0]        r_mem_addr;
  logic [3:0]         r_mem_wen;
  logic [31:0]        r_mem_wdata;

  // Response tag pipeline: stage 0 lines up with the registered address
  logic [STAGES-1:0]            r_tag_v;
  logic [STAGES-1:0][ID_W-1:0]  r_tag_id;

  // Find the first valid requester scanning from rr_ptr (requester 0 first when prioritised)
  always_comb begin
    int              v_idx;
    logic [ID_W-1:0] v_id;
    w_found  = 1'b0;
    w_win_id = '0;
    v_idx    = 0;
    v_id     = '0;
    if (PRIO_EN && req_valid[0]) begin
      w_found = 1'b1;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      v_id = ID_W'(v_idx);
      if (!w_found && req_valid[v_id] && !(PRIO_EN && (v_id == '0))) begin
        w_found  = 1'b1;
        w_win_id = v_id;
      end
    end
  end

  // One-hot ready for the winner; nothing is granted while reset is high
  always_comb begin
    w_grant  = '0;
    w_accept = w_found && !reset;
    if (w_accept) w_grant[w_win_id] = 1'b1;
  end

  // Select the winner's address, byte enables and write data
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wen   = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_id == ID_W'(i)) begin
        w_sel_addr  = req_addr[i*17 +: 17];
        w_sel_wen   = req_wen[i*4 +: 4];
        w_sel_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  // Next round-robin pointer: one past the winner; requester-0 priority grants leave it alone
  always_comb begin
    w_rr_next = r_rr_ptr;
    if (w_accept && !(PRIO_EN && (w_win_id == '0))) begin
      w_rr_next = (w_win_id == LAST_ID) ? '0 : w_win_id + ID_W'(1);
      if (PRIO_EN && (w_rr_next == '0)) w_rr_next = ID_W'(1);
    end
  end

  // Pointer update, issue-stage registers and tag pipeline shift
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_mem_addr  <= '0;
      r_mem_wen   <= '0;
      r_mem_wdata <= '0;
      r_tag_v     <= '0;
      r_tag_id    <= '0;
    end else begin
      r_rr_ptr <= w_rr_next;
      if (w_accept) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wen   <= w_sel_wen;
        r_mem_wdata <= w_sel_wdata;
      end else begin
        r_mem_wen   <= '0;
      end
      r_tag_v[0]  <= w_accept && (w_sel_wen == 4'h0);
      r_tag_id[0] <= w_win_id;
      for (int s = 1; s < STAGES; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  // Route read data to the requester named by the last tag stage
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (!reset && r_tag_v[STAGES-1]) begin
      rsp_valid[r_tag_id[STAGES-1]] = 1'b1;
      rsp_rdata                     = mem_rdata;
    end
  end

  // Memory port shows reset values from the first reset cycle on
  assign req_ready = w_grant;
  assign mem_addr  = reset ? 17'h0 : r_mem_addr;
  assign mem_wen   = reset ? 4'h0  : r_mem_wen;
  assign mem_wdata = reset ? 32'h0 : r_mem_wdata;

endmodule

// File: tb/tb_mlaccel_memory_arbiter.sv
// Bench for mlaccel_memory_arbiter: per-requester request queues drive the
// handshake, a behavioural 2-cycle memory sits on the memory port, and a
// scoreboard of expected read responses (id, data, cycle) is filled at
// acceptance and drained as responses appear.
module tb_mlaccel_memory_arbiter;

  localparam int NUM_REQ = 3;
  localparam int W       = 52;   // {cycle[15:0], id[3:0], data[31:0]}
`ifdef MLACCEL_MEMARB_PRIO_EN
  localparam int HOLD_BOUND = NUM_REQ + 5;
`else
  localparam int HOLD_BOUND = NUM_REQ;
`endif

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [17*NUM_REQ-1:0] req_addr;
  logic [4*NUM_REQ-1:0]  req_wen;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_rdata;
  logic [16:0]           mem_addr;
  logic [3:0]            mem_wen;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata = 32'h0;

  mlaccel_memory_arbiter #(.NUM_REQ(NUM_REQ), .RD_LATENCY(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wen   (req_wen),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // memory contents (DUT side) and reference contents (bench side)
  logic [31:0] mem_arr [int];
  logic [31:0] ref_arr [int];
  logic [31:0] rd_p1 = 32'h0;

  function automatic logic [31:0] init_word(input logic [14:0] w);
    return 32'hA5A5_0000 ^ {17'd0, w};
  endfunction

  function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [16:0] a);
    int k;
    k = int'(a[16:2]);
    if (mem_arr.exists(k)) return mem_arr[k];
    return init_word(a[16:2]);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [16:0] a);
    int k;
    k = int'(a[16:2]);
    if (ref_arr.exists(k)) return ref_arr[k];
    return init_word(a[16:2]);
  endfunction

  // memory: address sampled at the edge ending its cycle, data out one edge later
  always @(posedge clock) begin
    if (mem_wen != 4'h0) mem_arr[int'(mem_addr[16:2])] = apply_be(mem_rd(mem_addr), mem_wdata, mem_wen);
    rd_p1     <= mem_rd(mem_addr);
    mem_rdata <= rd_p1;
  end

  // bench state
  logic [52:0]  rq [NUM_REQ][$];   // {addr17, wen4, wdata32}
  logic [W-1:0] exp_q [$];
  int           grant_log [$];
  bit           prev_acc = 1'b0;
  logic [52:0]  prev_e = '0;
  int           rsp_seen = 0;
  logic [31:0]  last_rsp_data = '0;
  int           errors = 0;
  int           checks = 0;

  function automatic bit busy();
    bit b;
    b = (exp_q.size() != 0);
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // one clock cycle: drive from queues, sample at negedge, score, advance
  task automatic step();
    logic [52:0]  e;
    logic [W-1:0] x;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() != 0) begin
        e = rq[i][0];
        req_valid[i]            = 1'b1;
        req_addr[i*17 +: 17]    = e[52:36];
        req_wen[i*4 +: 4]       = e[35:32];
        req_wdata[i*32 +: 32]   = e[31:0];
      end else begin
        req_valid[i]            = 1'b0;
        req_addr[i*17 +: 17]    = 17'($urandom);
        req_wen[i*4 +: 4]       = 4'($urandom);
        req_wdata[i*32 +: 32]   = $urandom;
      end
    end
    @(negedge clock);
    if (reset) begin
      checks++;
      if (req_ready !== '0 || rsp_valid !== '0 || rsp_rdata !== '0 ||
          mem_addr !== '0 || mem_wen !== '0 || mem_wdata !== '0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b rsp_valid=%b rdata=%h addr=%h wen=%h wdata=%h, want all zero",
                 req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wen, mem_wdata);
      end
      exp_q.delete();
      prev_acc = 1'b0;
    end else begin
      checks++;
      if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != '0) ||
          ((req_valid != '0) && (req_ready == '0))) begin
        errors++;
        $display("FAIL grant_legal: ready=%b with valid=%b, want one-hot subset of valid", req_ready, req_valid);
      end
      checks++;
      if (prev_acc) begin
        if (mem_addr !== prev_e[52:36] || mem_wen !== prev_e[35:32] ||
            (prev_e[35:32] != 4'h0 && mem_wdata !== prev_e[31:0])) begin
          errors++;
          $display("FAIL issue_fields: got addr=%h wen=%h wdata=%h, want addr=%h wen=%h wdata=%h",
                   mem_addr, mem_wen, mem_wdata, prev_e[52:36], prev_e[35:32], prev_e[31:0]);
        end
      end else if (mem_wen !== 4'h0) begin
        errors++;
        $display("FAIL idle_wen: got mem_wen=%h, want 0", mem_wen);
      end
      if (rsp_valid != '0) begin
        checks++;
        rsp_seen++;
        last_rsp_data = rsp_rdata;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b data=%h at cycle %0d, want no response",
                   rsp_valid, rsp_rdata, cyc);
        end else begin
          x = exp_q.pop_front();
          if (rsp_valid !== (3'b001 << x[35:32]) || rsp_rdata !== x[31:0] || x[51:36] != cyc[15:0]) begin
            errors++;
            $display("FAIL rsp_match: got valid=%b data=%h cycle=%0d, want valid=%b data=%h cycle=%0d",
                     rsp_valid, rsp_rdata, cyc[15:0], 3'b001 << x[35:32], x[31:0], x[51:36]);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0][51:36] == cyc[15:0]) begin
        checks++;
        errors++;
        x = exp_q.pop_front();
        $display("FAIL rsp_missing: got no response at cycle %0d, want id=%0d data=%h", cyc, x[35:32], x[31:0]);
      end
      prev_acc = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && rq[i].size() != 0) begin
          e = rq[i].pop_front();
          grant_log.push_back(i);
          prev_acc = 1'b1;
          prev_e   = e;
          if (e[35:32] == 4'h0)
            exp_q.push_back({16'(cyc + 3), 4'(i), ref_rd(e[52:36])});
          else
            ref_arr[int'(e[52:38])] = apply_be(ref_rd(e[52:36]), e[31:0], e[35:32]);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
    grant_log.delete();
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && busy(); n++) step();
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL drain_timeout: got %0d responses outstanding, want 0", exp_q.size());
      exp_q.delete();
      for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    end
  endtask

  // reset values, ready suppressed while requests are pending, first grant to req 0
  task automatic test_reset();
    int exp_g [3] = '{0, 1, 2};
    for (int i = 0; i < NUM_REQ; i++) rq[i].push_back({17'(32'h40 + i * 4), 4'h0, 32'h0});
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    grant_log.delete();
    drain();
    checks++;
    if (grant_log.size() != 3) begin
      errors++;
      $display("FAIL reset_grant_count: got %0d, want 3", grant_log.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (grant_log[k] != exp_g[k]) begin
          errors++;
          $display("FAIL reset_grant_order[%0d]: got %0d, want %0d", k, grant_log[k], exp_g[k]);
        end
      end
    end
  endtask

  // single read by requester 1 of a preloaded word
  task automatic test_single_read();
    int seen0;
    mem_arr[4] = 32'hDEAD_BEEF;
    ref_arr[4] = 32'hDEAD_BEEF;
    grant_log.delete();
    seen0 = rsp_seen;
    rq[1].push_back({17'h00010, 4'h0, 32'h0});
    drain();
    checks++;
    if (grant_log.size() != 1 || grant_log[0] != 1) begin
      errors++;
      $display("FAIL single_read_grant: got %0d grants, want one grant to req 1", grant_log.size());
    end
    checks++;
    if (rsp_seen - seen0 != 1 || last_rsp_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_read_data: got %0d rsp data=%h, want 1 rsp data=deadbeef", rsp_seen - seen0, last_rsp_data);
    end
  endtask

  // write then read same address, including a partial byte-enable write
  task automatic test_write_read();
    int seen0;
    seen0 = rsp_seen;
    rq[0].push_back({17'h00100, 4'hF, 32'h1234_5678});
    rq[0].push_back({17'h00100, 4'h0, 32'h0});
    drain();
    checks++;
    if (rsp_seen - seen0 != 1 || last_rsp_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_read_full: got %0d rsp data=%h, want 1 rsp data=12345678", rsp_seen - seen0, last_rsp_data);
    end
    seen0 = rsp_seen;
    rq[0].push_back({17'h00100, 4'h3, 32'hAAAA_5555});
    rq[0].push_back({17'h00100, 4'h0, 32'h0});
    drain();
    checks++;
    if (rsp_seen - seen0 != 1 || last_rsp_data !== 32'h1234_5555) begin
      errors++;
      $display("FAIL write_read_partial: got %0d rsp data=%h, want 1 rsp data=12345555", rsp_seen - seen0, last_rsp_data);
    end
  endtask

  // all three requesters continuously valid with reads
  task automatic test_round_robin();
    int exp_g [6] = '{0, 1, 2, 0, 1, 2};
    int seen0;
    do_reset(2);
    seen0 = rsp_seen;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NUM_REQ; i++) rq[i].push_back({17'(32'h800 + i * 32'h40 + k * 4), 4'h0, 32'h0});
    drain();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= grant_log.size() || grant_log[k] != exp_g[k]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d, want %0d", k, (k < grant_log.size()) ? grant_log[k] : -1, exp_g[k]);
      end
    end
    checks++;
    if (rsp_seen - seen0 != 6) begin
      errors++;
      $display("FAIL rr_rsp_count: got %0d, want 6", rsp_seen - seen0);
    end
  endtask

  // requester 2 joins while 0 and 1 stream; it must be served promptly
  task automatic test_hold();
    int waited;
    do_reset(2);
    for (int k = 0; k < 5; k++) begin
      rq[0].push_back({17'(32'h1000 + k * 4), 4'h0, 32'h0});
      rq[1].push_back({17'(32'h1100 + k * 4), 4'h0, 32'h0});
    end
    repeat (3) step();
    rq[2].push_back({17'h01F03, 4'h0, 32'h0});
    waited = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      waited = n;
      if (rq[2].size() == 0) break;
    end
    checks++;
    if (rq[2].size() != 0 || waited > HOLD_BOUND) begin
      errors++;
      $display("FAIL hold_wait: got grant after %0d cycles (pending=%0d), want <= %0d", waited, rq[2].size(), HOLD_BOUND);
    end
    drain();
  endtask

  // reset one cycle after a read grant drops its response; grant restarts at req 0
  task automatic test_reset_midflight();
    int seen0;
    do_reset(2);
    rq[1].push_back({17'h00200, 4'h0, 32'h0});
    step();
    seen0 = rsp_seen;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();
    checks++;
    if (rsp_seen != seen0) begin
      errors++;
      $display("FAIL midflight_dropped: got %0d responses after reset, want 0", rsp_seen - seen0);
    end
    grant_log.delete();
    rq[2].push_back({17'h00300, 4'h0, 32'h0});
    rq[1].push_back({17'h00304, 4'h0, 32'h0});
    rq[0].push_back({17'h00308, 4'h0, 32'h0});
    drain();
    checks++;
    if (grant_log.size() == 0 || grant_log[0] != 0) begin
      errors++;
      $display("FAIL midflight_resume: got first grant %0d, want 0", (grant_log.size() != 0) ? grant_log[0] : -1);
    end
  endtask

  // req 0 has four back-to-back requests alongside one each from 1 and 2
  task automatic test_prio();
`ifdef MLACCEL_MEMARB_PRIO_EN
    int exp_g [6] = '{0, 0, 0, 0, 1, 2};
`else
    int exp_g [6] = '{0, 1, 2, 0, 0, 0};
`endif
    do_reset(2);
    for (int k = 0; k < 4; k++) rq[0].push_back({17'(32'h2000 + k * 4), 4'h0, 32'h0});
    rq[1].push_back({17'h02100, 4'h0, 32'h0});
    rq[2].push_back({17'h02200, 4'h0, 32'h0});
    drain();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= grant_log.size() || grant_log[k] != exp_g[k]) begin
        errors++;
        $display("FAIL prio_order[%0d]: got %0d, want %0d", k, (k < grant_log.size()) ? grant_log[k] : -1, exp_g[k]);
      end
    end
  endtask

  // random mix of reads/writes on a small window, unaligned addresses included
  task automatic test_random();
    logic [16:0] a;
    logic [3:0]  be;
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq[i].size() < 2 && $urandom_range(0, 2) != 0) begin
          a  = 17'h00400 + 17'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
          be = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
          rq[i].push_back({a, be, 32'($urandom)});
        end
      end
      step();
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_wen   = '0;
    req_wdata = '0;
    @(posedge clock);
    #1;
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_hold();
    test_reset_midflight();
    test_prio();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
